// File: rtl/timer_pkg.sv
// Shared definitions for the game countdown timer: FSM encoding, BCD digit
// limits, the low-time warning threshold and small digit helpers.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] MAX_ONES  = 4'd9;
  localparam logic [2:0] MAX_TENS  = 3'd5;
  localparam logic [9:0] WARN_SECS = 10'd10;

  function automatic logic [3:0] clamp_ones(input logic [3:0] v);
    return (v > MAX_ONES) ? MAX_ONES : v;
  endfunction

  function automatic logic [2:0] clamp_tens(input logic [2:0] v);
    return (v > MAX_TENS) ? MAX_TENS : v;
  endfunction

  // Total remaining seconds; 9:59 = 599 fits in 10 bits.
  function automatic logic [9:0] to_secs(input logic [3:0] mins,
                                         input logic [2:0] tens,
                                         input logic [3:0] ones);
    return 10'(mins) * 10'd60 + 10'(tens) * 10'd10 + 10'(ones);
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One down-counting BCD digit: synchronous load, decrement enable, wrap from
// 0 to MAX, and borrow_out flagging that the digit currently reads 0.
module bcd_digit_down #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   MAX     = W'(9),
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec_en,
  output logic [W-1:0] value,
  output logic         borrow_out
);

  logic [W-1:0] value_q, value_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    value_d = value_q;
    if (load)        value_d = load_val;
    else if (dec_en) value_d = (value_q == '0) ? MAX : value_q - W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) value_q <= RST_VAL;
    else       value_q <= value_d;
  end

  assign value      = value_q;
  assign borrow_out = (value_q == '0);

endmodule

// File: rtl/game_countdown_timer.sv
// mm:ss round timer advanced only by sec_tick strobes; flags expiry to the game FSM.
// Optional low-time blink on `warn` is enabled by defining TIMER_WARN_EN.
module game_countdown_timer
  import timer_pkg::*;
#(
  parameter logic [3:0] DEF_MIN      = 4'd1,
  parameter logic [2:0] DEF_SEC_TENS = 3'd0,
  parameter logic [3:0] DEF_SEC_ONES = 4'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       halfsec_tick,
  input  logic       start,
  input  logic       pause,
  input  logic [3:0] load_min,
  input  logic [2:0] load_sec_tens,
  input  logic [3:0] load_sec_ones,
  output logic [3:0] min_bcd,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       expired,
  output logic       timeout,
  output logic       warn
);

  state_t     state_q, state_d;
  logic       running_q, expired_q, timeout_q, timeout_d;
  logic [3:0] ld_min, ld_ones, min_q, ones_q;
  logic [2:0] ld_tens, tens_q;
  logic       ones_borrow, tens_borrow, min_borrow;
  logic       do_dec, hits_zero, load_zero;

  assign ld_min  = clamp_ones(load_min);
  assign ld_tens = clamp_tens(load_sec_tens);
  assign ld_ones = clamp_ones(load_sec_ones);

  // start outranks everything, so a same-cycle tick never decrements the old value.
  assign do_dec    = !start && (state_q == RUN) && sec_tick;
  assign hits_zero = do_dec && (ones_q == 4'd1) && tens_borrow && min_borrow;
  assign load_zero = (ld_min == 4'd0) && (ld_tens == 3'd0) && (ld_ones == 4'd0);

  bcd_digit_down #(.W(4), .MAX(MAX_ONES), .RST_VAL(DEF_SEC_ONES)) u_ones (
    .clock(clock), .reset(reset), .load(start), .load_val(ld_ones),
    .dec_en(do_dec), .value(ones_q), .borrow_out(ones_borrow)
  );

  bcd_digit_down #(.W(3), .MAX(MAX_TENS), .RST_VAL(DEF_SEC_TENS)) u_tens (
    .clock(clock), .reset(reset), .load(start), .load_val(ld_tens),
    .dec_en(do_dec && ones_borrow), .value(tens_q), .borrow_out(tens_borrow)
  );

  bcd_digit_down #(.W(4), .MAX(MAX_ONES), .RST_VAL(DEF_MIN)) u_min (
    .clock(clock), .reset(reset), .load(start), .load_val(ld_min),
    .dec_en(do_dec && ones_borrow && tens_borrow), .value(min_q), .borrow_out(min_borrow)
  );

  always_comb begin
    state_d   = state_q;
    timeout_d = 1'b0;
    if (start) begin
      if (load_zero) begin
        state_d   = DONE;
        timeout_d = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          // Reaching 0:00 wins over a simultaneous pause.
          if (hits_zero) begin
            state_d   = DONE;
            timeout_d = 1'b1;
          end else if (pause) begin
            state_d = PAUSED;
          end
        end
        PAUSED:  if (pause) state_d = RUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == RUN);
      expired_q <= (state_d == DONE);
      timeout_q <= timeout_d;
    end
  end

`ifdef TIMER_WARN_EN
  logic warn_q, warn_d;
  logic low_time;

  assign low_time = (to_secs(min_q, tens_q, ones_q) <= WARN_SECS);

  // Blink only while staying in RUN; any exit, reload or high time forces 0.
  always_comb begin
    warn_d = 1'b0;
    if (!start && (state_q == RUN) && (state_d == RUN) && low_time)
      warn_d = (sec_tick || halfsec_tick) ? !warn_q : warn_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) warn_q <= 1'b0;
    else       warn_q <= warn_d;
  end

  assign warn = warn_q;
`else
  logic unused_halfsec;
  assign unused_halfsec = halfsec_tick;
  assign warn           = 1'b0;
`endif

  assign min_bcd  = min_q;
  assign sec_tens = tens_q;
  assign sec_ones = ones_q;
  assign running  = running_q;
  assign expired  = expired_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed self-checking bench for game_countdown_timer (default parameters, 1:00 at reset).
// Warn expectations follow whether TIMER_WARN_EN is defined for the build.
module tb_game_countdown_timer;

`ifdef TIMER_WARN_EN
  localparam bit WARN_ON = 1'b1;
`else
  localparam bit WARN_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sec_tick = 1'b0, halfsec_tick = 1'b0, start = 1'b0, pause = 1'b0;
  logic [3:0] load_min = 4'd0, load_sec_ones = 4'd0;
  logic [2:0] load_sec_tens = 3'd0;
  logic [3:0] min_bcd, sec_ones;
  logic [2:0] sec_tens;
  logic       running, expired, timeout, warn;

  int total = 0;
  int bad   = 0;

  game_countdown_timer dut (
    .clock(clock), .reset(reset), .sec_tick(sec_tick), .halfsec_tick(halfsec_tick),
    .start(start), .pause(pause), .load_min(load_min), .load_sec_tens(load_sec_tens),
    .load_sec_ones(load_sec_ones), .min_bcd(min_bcd), .sec_tens(sec_tens),
    .sec_ones(sec_ones), .running(running), .expired(expired), .timeout(timeout),
    .warn(warn)
  );

  always #10 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Displayed time as m*100 + tens*10 + ones, e.g. 2:09 -> 209.
  function automatic int shown();
    return int'(min_bcd) * 100 + int'(sec_tens) * 10 + int'(sec_ones);
  endfunction

  // One clock: inputs applied at the falling edge, outputs sampled 1 ns after the rising edge.
  task automatic step(input logic st, input logic ps, input logic tk, input logic ht);
    @(negedge clock);
    start = st; pause = ps; sec_tick = tk; halfsec_tick = ht;
    @(posedge clock);
    #1;
    start = 1'b0; pause = 1'b0; sec_tick = 1'b0; halfsec_tick = 1'b0;
  endtask

  task automatic do_start(input logic [3:0] m, input logic [2:0] t, input logic [3:0] o);
    load_min = m; load_sec_tens = t; load_sec_ones = o;
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One sec_tick every 10 cycles.
  task automatic slow_tick();
    idle(9);
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset state
    #25;
    check("rst_digits", shown(), 100);
    check("rst_running", running, 0);
    check("rst_expired", expired, 0);
    check("rst_timeout", timeout, 0);
    check("rst_warn", warn, 0);
    @(negedge clock);
    reset = 1'b0;

    // pause and sec_tick are ignored in IDLE
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("idle_digits", shown(), 100);
    check("idle_running", running, 0);

    // 0:03 counted down at one tick per 10 cycles
    do_start(4'd0, 3'd0, 4'd3);
    check("s3_digits", shown(), 3);
    check("s3_running", running, 1);
    slow_tick();
    check("t1_digits", shown(), 2);
    slow_tick();
    check("t2_digits", shown(), 1);
    check("t2_timeout", timeout, 0);
    slow_tick();
    check("t3_digits", shown(), 0);
    check("t3_timeout", timeout, 1);
    check("t3_expired", expired, 1);
    check("t3_running", running, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("done_hold", shown(), 0);
    check("done_timeout_once", timeout, 0);
    check("done_expired", expired, 1);

    // BCD borrows
    do_start(4'd1, 3'd0, 4'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("borrow_100", shown(), 59);
    do_start(4'd2, 3'd1, 4'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("borrow_210", shown(), 209);

    // Pause holds, resume continues
    do_start(4'd0, 3'd4, 4'd5);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("paused_running", running, 0);
    repeat (5) slow_tick();
    check("paused_hold", shown(), 45);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("resumed_running", running, 1);
    slow_tick();
    check("resumed_tick", shown(), 44);

    // pause + tick together
    do_start(4'd0, 3'd3, 4'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("pt_digits", shown(), 29);
    check("pt_running", running, 0);
    check("pt_expired", expired, 0);
    do_start(4'd0, 3'd0, 4'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("pt0_digits", shown(), 0);
    check("pt0_expired", expired, 1);
    check("pt0_timeout", timeout, 1);
    check("pt0_running", running, 0);

    // Zero load and clamping
    do_start(4'd5, 3'd2, 4'd0);
    do_start(4'd0, 3'd0, 4'd0);
    check("z_digits", shown(), 0);
    check("z_expired", expired, 1);
    check("z_timeout", timeout, 1);
    check("z_running", running, 0);
    idle(1);
    check("z_timeout_once", timeout, 0);
    do_start(4'd12, 3'd7, 4'd3);
    check("clamp_min_tens", shown(), 953);
    do_start(4'd5, 3'd6, 4'd15);
    check("clamp_tens_ones", shown(), 559);

    // Held-high tick decrements every cycle
    do_start(4'd0, 3'd0, 4'd5);
    @(negedge clock);
    sec_tick = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    sec_tick = 1'b0;
    check("held_tick", shown(), 3);

    // Asynchronous reset mid-count, sampled between clock edges
    do_start(4'd0, 3'd4, 4'd5);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("pre_reset", shown(), 44);
    #3;
    reset = 1'b1;
    #1;
    check("arst_digits", shown(), 100);
    check("arst_running", running, 0);
    @(negedge clock);
    reset = 1'b0;
    idle(2);
    check("arst_timeout", timeout, 0);
    check("arst_still_idle", running, 0);

    // Low-time warning blink
    do_start(4'd0, 3'd1, 4'd2);
    check("w12", warn, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("w11_tick", warn, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("w11_half", warn, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("w10_digits", shown(), 10);
    check("w10_tick", warn, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("w10_half", warn, WARN_ON ? 1 : 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("w09_tick", warn, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("w09_half", warn, WARN_ON ? 1 : 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("w_paused", warn, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("w_resumed", warn, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("w_resumed_half", warn, WARN_ON ? 1 : 0);
    repeat (9) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("w_done_digits", shown(), 0);
    check("w_done_expired", expired, 1);
    check("w_done_warn", warn, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_countdown_timer.md
# game_countdown_timer

Tick-driven mm:ss countdown timer that consumes the single-cycle `sec_tick` / `halfsec_tick` strobes produced by the board's one-second tick generator. It times a round of the game, drives BCD digits to the seven-segment decoders, and flags expiry to the game FSM. It is the consumer end of the tick interface: it never divides the clock itself and only advances on strobes.

## Interface
- `DEF_MIN`, 4'd1, minutes value loaded at reset (BCD, 0–9)
- `DEF_SEC_TENS`, 3'd0, seconds-tens value loaded at reset (0–5)
- `DEF_SEC_ONES`, 4'd0, seconds-ones value loaded at reset (0–9)

Ports (reset: `reset`, asynchronous, active-high; clock: `clock`):
- `clock`  in  1  system clock (50 MHz)
- `reset`  in  1  asynchronous, active-high
- `sec_tick`  in  1  one-cycle strobe, once per second
- `halfsec_tick`  in  1  one-cycle strobe, mid-second
- `start`  in  1  one-cycle pulse: load `load_*` and run
- `pause`  in  1  one-cycle pulse: toggle RUN/PAUSED
- `load_min`  in  4  BCD minutes to load
- `load_sec_tens`  in  3  seconds tens to load
- `load_sec_ones`  in  4  seconds ones to load
- `min_bcd`  out  4  remaining minutes
- `sec_tens`  out  3  remaining seconds tens
- `sec_ones`  out  4  remaining seconds ones
- `running`  out  1  high in RUN
- `expired`  out  1  high in DONE
- `timeout`  out  1  one-cycle pulse on reaching 0:00
- `warn`  out  1  low-time blink (see Configuration)

## Operation
- States: IDLE, RUN, PAUSED, DONE. Reset → IDLE, digits = DEF_*, all status outputs 0.
- `start` (any state, highest priority): latch the load digits and go to RUN. If the loaded value is 0:00, go to DONE instead and pulse `timeout`.
- Load clamping: `load_min` or `load_sec_ones` > 9 loads 9; `load_sec_tens` > 5 loads 5.
- RUN + `sec_tick`: decrement mm:ss by one second with BCD borrow (x:00 → (x-1):59). When the result is 0:00, go to DONE and pulse `timeout`.
- RUN + `pause` → PAUSED. PAUSED + `pause` → RUN. `pause` is ignored in IDLE and DONE.
- RUN with `pause` and `sec_tick` in the same cycle: the decrement is applied and the state becomes PAUSED. If the decrement reaches 0:00, the state becomes DONE and `pause` is ignored.
- `sec_tick` is ignored in IDLE, PAUSED and DONE.
- DONE holds 0:00 until `start` or `reset`.
- `running` = (state == RUN). `expired` = (state == DONE). Both are decoded from a registered state, with no combinational path from inputs.

## Timing
- All outputs are registered. Digits update on the first rising edge at which `sec_tick` is sampled high, so latency is 1 cycle.
- `timeout` is high for exactly one cycle, on the same edge at which the digits reach 0:00 and `expired` rises.
- `start`: the new digits and `running` are visible on the edge after `start` is sampled.
- `reset` mid-count: all state clears asynchronously. There are no pending pulses after release.
- The tick strobes are assumed synchronous to `clock` and one cycle wide. A held-high tick decrements once per cycle; no edge detection is performed.

## Configuration
- `TIMER_WARN_EN` defined:
  - In RUN, while remaining ≤ 0:10, `warn` toggles on every `sec_tick` and every `halfsec_tick`, giving a 1 Hz blink.
  - `warn` is cleared to 0 on leaving RUN and whenever remaining > 0:10.
  - Reset value is 0.
- Not defined: `warn` is tied to 0 and `halfsec_tick` is unused.

## Structure
- Shared package/include `timer_pkg`:
  - state encoding (IDLE=0, RUN=1, PAUSED=2, DONE=3)
  - digit maxima `MAX_ONES`=9, `MAX_TENS`=5
  - warn threshold `WARN_SECS`=10
- Sub-module `bcd_digit_down` (parameter MAX): one digit with synchronous load, decrement enable, wrap to MAX, and a `borrow_out` flag when at 0. It is instantiated three times and chained through borrows.

## Test plan
- Reset, then `start` with 0:03 and a `sec_tick` every 10 cycles → digits step 0:02, 0:01, 0:00. `timeout` is high for 1 cycle at the third tick, `expired`=1 and `running`=0.
- Load 1:00 and apply one tick → 0:59. Load 2:10 and apply one tick → 2:09.
- RUN at 0:45, `pause`, 5 ticks → holds 0:45. Then `pause` and 1 tick → 0:44.
- `pause` and `sec_tick` in the same cycle at 0:30 → 0:29 and state PAUSED. At 0:01, the same pair → 0:00, DONE, `timeout` pulse.
- `start` with load 0:00 → DONE with a `timeout` pulse. Load min=12, tens=7 → clamps to 9:5x.
- With `TIMER_WARN_EN`, from 0:12 apply ticks and halfticks → `warn` is 0 until 0:10, then toggles on each strobe, and returns to 0 in DONE. Without the macro, `warn` is always 0.
